// File: rtl/nios_button_pio_if.sv
// Avalon-MM slave bus bundle for the button/switch input PIO.
// Zero-wait-state, read-latency-0: readdata is a combinational mux.
interface nios_button_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_button_pio.sv
// Push-button/switch input PIO: per-pin sync -> debounce -> edge detect -> sticky
// capture, with a maskable level interrupt and an Avalon-MM register window.

// One input pin: synchronizer, debounce filter, edge detector and capture bit.
module nios_button_pio_lane #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1,
  parameter int IDLE_LEVEL      = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  input  logic clr,
  output logic db,
  output logic cap
);
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic          IDLE     = 1'(IDLE_LEVEL);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2, db_d, ev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db  <= IDLE;
      cnt <= '0;
    end else if (sync2 == db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      db  <= sync2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) db_d <= IDLE;
    else          db_d <= db;
  end

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign ev = db & ~db_d;
    end else if (EDGE_TYPE == 2) begin : g_any
      assign ev = db ^ db_d;
    end else begin : g_fall
      assign ev = ~db & db_d;
    end
  endgenerate

  // Set has priority over a same-cycle write-1-to-clear so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cap <= 1'b0;
    else if (ev)   cap <= 1'b1;
    else if (clr)  cap <= 1'b0;
  end
endmodule

module nios_button_pio #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1,
  parameter int IDLE_LEVEL      = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  nios_button_pio_if.slave   avs,
  input  logic [WIDTH-1:0]   in_port,
  output logic               irq
);
  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MASK = 2'd2;
  localparam logic [1:0] A_EDGE = 2'd3;

  logic [WIDTH-1:0] db, edge_capture, irq_mask, w1c;
  logic             wr;
  logic [31:0]      rdata;

  assign wr  = avs.chipselect && !avs.write_n;
  assign w1c = (wr && avs.address == A_EDGE) ? avs.writedata[WIDTH-1:0] : '0;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      nios_button_pio_lane #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .EDGE_TYPE       (EDGE_TYPE),
        .IDLE_LEVEL      (IDLE_LEVEL)
      ) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (in_port[i]),
        .clr     (w1c[i]),
        .db      (db[i]),
        .cap     (edge_capture[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         irq_mask <= '0;
    else if (wr && avs.address == A_MASK) irq_mask <= avs.writedata[WIDTH-1:0];
  end

  // Reads are side-effect free and ignore chipselect.
  always_comb begin
    rdata = '0;
    case (avs.address)
      A_DATA:  rdata[WIDTH-1:0] = db;
      A_MASK:  rdata[WIDTH-1:0] = irq_mask;
      A_EDGE:  rdata[WIDTH-1:0] = edge_capture;
      default: rdata = '0;
    endcase
  end

  assign avs.readdata = rdata;
  assign irq          = |(edge_capture & irq_mask);
endmodule

// File: tb/tb_nios_button_pio.sv
// Directed bench for nios_button_pio (WIDTH=5, DEBOUNCE_CYCLES=4, falling edge, idle high).
// Expected values are queued as stimulus is applied and popped at each check point.
module tb_nios_button_pio;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] in_port = 5'h1F;
  logic       irq;

  nios_button_pio_if bus ();

  nios_button_pio #(
    .WIDTH(5), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IDLE_LEVEL(1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: got %h, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: got %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic rdchk(input logic [1:0] a, input string tag);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = a;
    #1;
    check(tag, bus.readdata);
  endtask

  task automatic irqchk(input string tag);
    #1;
    check(tag, {31'b0, irq});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.write_n    = 1'b1;
    bus.chipselect = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    tick(2);
    reset_n = 1'b1;

    // Reset values
    push(32'h1F); push(32'h0); push(32'h0); push(32'h0);
    rdchk(2'd0, "rst_data"); rdchk(2'd2, "rst_mask"); rdchk(2'd3, "rst_edge"); irqchk("rst_irq");

    // Bit 0 falling edge, unmasked: DATA at edge 6, capture/irq at edge 7
    wr(2'd2, 32'h01);
    in_port = 5'h1E;
    push(32'h1F);
    tick(5); rdchk(2'd0, "data_e5");
    push(32'h1E); push(32'h0); push(32'h0);
    tick(1); rdchk(2'd0, "data_e6"); rdchk(2'd3, "edge_e6"); irqchk("irq_e6");
    push(32'h01); push(32'h1);
    tick(1); rdchk(2'd3, "edge_e7"); irqchk("irq_e7");

    // W1C clears, write of 0 leaves pending bits alone
    wr(2'd3, 32'h01);
    push(32'h0); push(32'h0);
    rdchk(2'd3, "w1c_edge"); irqchk("w1c_irq");
    in_port = 5'h1C;
    push(32'h02);
    tick(7); rdchk(2'd3, "bit1_cap");
    wr(2'd3, 32'h00);
    push(32'h02); push(32'h0);
    rdchk(2'd3, "w0_keep"); irqchk("masked_irq");
    wr(2'd3, 32'h02);
    push(32'h0);
    rdchk(2'd3, "bit1_clr");

    // Glitch filtering on bit 2: 3-cycle pulse rejected, 4-cycle pulse accepted
    in_port = 5'h18; tick(3); in_port = 5'h1C;
    push(32'h1C); push(32'h0);
    tick(8); rdchk(2'd0, "glitch3_data"); rdchk(2'd3, "glitch3_edge");
    in_port = 5'h18; tick(4); in_port = 5'h1C;
    push(32'h04); push(32'h1C);
    tick(8); rdchk(2'd3, "pulse4_edge"); rdchk(2'd0, "pulse4_data");
    wr(2'd3, 32'h04);

    // Capture persists while masked; unmasking raises irq
    wr(2'd2, 32'h00);
    in_port = 5'h14;
    push(32'h08); push(32'h0);
    tick(7); rdchk(2'd3, "bit3_cap"); irqchk("bit3_masked_irq");
    wr(2'd2, 32'h08);
    push(32'h1);
    irqchk("unmask_irq");
    wr(2'd3, 32'h08);
    push(32'h0);
    irqchk("clr_irq");

    // Rising edge ignored, then falling edge coincident with W1C: set wins
    in_port = 5'h15;
    push(32'h0); push(32'h15);
    tick(8); rdchk(2'd3, "rise_ignored"); rdchk(2'd0, "rise_data");
    in_port = 5'h14;
    push(32'h0);
    tick(6); rdchk(2'd3, "coinc_pre");
    wr(2'd3, 32'h01);
    push(32'h01); push(32'h0);
    rdchk(2'd3, "coinc_set_wins"); irqchk("coinc_irq");

    // Asynchronous reset mid-debounce
    in_port = 5'h1F;
    tick(3);
    push(32'h1F); push(32'h0); push(32'h0); push(32'h0);
    #1 reset_n = 1'b0;
    rdchk(2'd0, "arst_data"); rdchk(2'd2, "arst_mask"); rdchk(2'd3, "arst_edge"); irqchk("arst_irq");

    // Pin held non-idle through reset yields an edge after release
    in_port = 5'h1E;
    @(negedge clk);
    reset_n = 1'b1;
    push(32'h0); push(32'h1E); push(32'h01);
    tick(6); rdchk(2'd3, "post_rst_e6"); rdchk(2'd0, "post_rst_data");
    tick(1); rdchk(2'd3, "post_rst_e7");

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
